// File: rtl/e_mdu_issue_ctrl.sv
// E-stage issue controller for the multi-cycle MDU: drives MDUOp/D1/D2/Start, tracks the Busy
// handshake, stalls on MDU structural hazards, returns HI/LO for mfhi/mflo and flags protocol errors.
module e_mdu_issue_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned SLACK       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  output logic [2:0]  MDUOp,
  output logic [31:0] D1,
  output logic [31:0] D2,
  output logic        Start,
  input  logic        Busy,
  input  logic [31:0] HI,
  input  logic [31:0] LO,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        err
);

  localparam int unsigned CW = 5;
  localparam int unsigned DW = 32;

  localparam logic [CW-1:0] MULT_LIM = CW'(MULT_CYCLES + SLACK);
  localparam logic [CW-1:0] DIV_LIM  = CW'(DIV_CYCLES + SLACK);
  localparam logic [CW-1:0] WCNT_MAX = '1;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [2:0] MDU_NONE = 3'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] lim_q, lim_d;
  logic          err_q, err_d;

  logic is_muldiv, is_mdop, is_read, engaged;
  logic start_w, stall_w;

  // Op-class decode of the instruction currently in E
  always_comb begin
    is_muldiv = (e_op >= OP_MULT) && (e_op <= OP_DIVU);
    is_mdop   = (e_op >= OP_MULT) && (e_op <= OP_MTLO);
    is_read   = (e_op == OP_MFHI) || (e_op == OP_MFLO);
    engaged   = (state_q != S_IDLE) || Busy;
  end

  // A pending flush wins over any MDU hazard, so Req never stalls
  always_comb begin
    stall_w = !Req && (is_mdop || is_read) && engaged;
    start_w = (state_q == S_IDLE) && !Busy && is_muldiv && !Req;
  end

  always_comb begin
    Start   = start_w;
    stall   = stall_w;
    D1      = e_rs;
    D2      = e_rt;
    MDUOp   = MDU_NONE;
    rd_data = '0;
    if (is_mdop && !stall_w && !Req) begin
      MDUOp = e_op[2:0];
    end
    if (!stall_w) begin
      if (e_op == OP_MFHI) begin
        rd_data = HI;
      end else if (e_op == OP_MFLO) begin
        rd_data = LO;
      end else begin
        rd_data = DW'(0);
      end
    end
  end

  // Next-state logic: ARM expects Busy to rise, WAIT watches for the fall or a timeout
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    lim_d   = lim_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_w) begin
          state_d = S_ARM;
          wcnt_d  = '0;
          lim_d   = ((e_op == OP_DIV) || (e_op == OP_DIVU)) ? DIV_LIM : MULT_LIM;
        end
      end
      S_ARM: begin
        if (Busy) begin
          state_d = S_WAIT;
        end else if (!Req) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!Busy) begin
          state_d = S_IDLE;
        end else begin
          if (!Req && (wcnt_q != WCNT_MAX)) begin
            wcnt_d = wcnt_q + CW'(1);
          end
          if (wcnt_q == lim_q) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      lim_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      lim_q   <= lim_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

  // OP_NONE is kept only as a named code for readability of the decode
  logic unused_none;
  assign unused_none = (e_op == OP_NONE);

endmodule

// File: tb/tb_e_mdu_issue_ctrl.sv
// Scoreboard bench for e_mdu_issue_ctrl with a behavioural MDU model (normal, no-Busy, long-Busy modes).
module tb_e_mdu_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        Req;
  logic [3:0]  e_op;
  logic [31:0] e_rs, e_rt;
  logic [2:0]  MDUOp;
  logic [31:0] D1, D2;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;
  logic        stall;
  logic [31:0] rd_data;
  logic        err;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
  } iss_t;

  iss_t        iss_q[$];
  logic [31:0] rd_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int mode = 0;  // 0 normal, 1 never raises Busy, 2 holds Busy 20 cycles

  e_mdu_issue_ctrl dut (
    .clk(clk), .reset(reset), .Req(Req), .e_op(e_op), .e_rs(e_rs), .e_rt(e_rt),
    .MDUOp(MDUOp), .D1(D1), .D2(D2), .Start(Start), .Busy(Busy), .HI(HI), .LO(LO),
    .stall(stall), .rd_data(rd_data), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural MDU: Busy rises after Start, countdown frozen under Req, HI/LO written as Busy falls
  int          busy_cnt = 0;
  logic [2:0]  pend_op;
  logic [31:0] pa, pb;
  always @(posedge clk) begin
    logic [63:0] prod;
    if (!reset) begin
      Busy     <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      busy_cnt = 0;
    end else begin
      if (Start) begin
        pend_op = MDUOp;
        pa      = D1;
        pb      = D2;
        if (mode != 1) begin
          busy_cnt = (mode == 2) ? 20 : ((MDUOp >= 3'd3) ? 10 : 5);
          Busy     <= 1'b1;
        end
      end else if (busy_cnt > 0 && !Req) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          Busy <= 1'b0;
          case (pend_op)
            3'd1: begin
              prod = {{32{pa[31]}}, pa} * {{32{pb[31]}}, pb};
              HI <= prod[63:32]; LO <= prod[31:0];
            end
            3'd2: begin
              prod = {32'd0, pa} * {32'd0, pb};
              HI <= prod[63:32]; LO <= prod[31:0];
            end
            3'd3: begin
              LO <= 32'($signed(pa) / $signed(pb));
              HI <= 32'($signed(pa) % $signed(pb));
            end
            default: begin
              LO <= pa / pb;
              HI <= pa % pb;
            end
          endcase
        end
      end
      if (MDUOp == 3'd5) HI <= D1;
      if (MDUOp == 3'd6) LO <= D1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT issues to the MDU or completes a read
  always @(negedge clk) begin
    if (reset) begin
      if (MDUOp != 3'd0) begin
        if (iss_q.size() == 0) begin
          chk("unexpected_issue", {29'd0, MDUOp}, 32'd0);
        end else begin
          iss_t e;
          e = iss_q.pop_front();
          chk("issue_op", {29'd0, MDUOp}, {29'd0, e.op});
          chk("issue_d1", D1, e.d1);
          chk("issue_d2", D2, e.d2);
        end
      end
      if ((e_op == 4'd7) || (e_op == 4'd8)) begin
        if (stall) begin
          chk("rd_data_stalled", rd_data, 32'd0);
        end else if (rd_q.size() == 0) begin
          chk("unexpected_read", rd_data, 32'hDEADBEEF);
        end else begin
          chk("rd_data", rd_data, rd_q.pop_front());
        end
      end
    end
  end

  // Hold an op in E until it is accepted; reports stall cycles and Start on the accept cycle
  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output int nstall, output logic started);
    bit done = 0;
    nstall  = 0;
    started = 1'b0;
    e_op = op; e_rs = rs; e_rt = rt; Req = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (!stall) begin
        done    = 1;
        started = Start;
      end else begin
        nstall++;
        chk("mduop_none_while_stalled", {29'd0, MDUOp}, 32'd0);
        chk("no_start_while_stalled", {31'd0, Start}, 32'd0);
        @(posedge clk); #1;
      end
    end
    if (!done) chk("stall_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    e_op = 4'd0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; e_op = 4'd0; Req = 1'b0; e_rs = '0; e_rt = '0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ns;
    logic st;
    reset = 1'b0; Req = 1'b0; e_op = 4'd0; e_rs = '0; e_rt = '0;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_start", {31'd0, Start}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mduop", {29'd0, MDUOp}, 32'd0);
    chk("rst_err",   {31'd0, err},   32'd0);
    @(posedge clk); #1;

    // 2: signed mult -1*2 then mflo/mfhi
    iss_q.push_back('{op: 3'd1, d1: 32'hFFFFFFFF, d2: 32'd2});
    issue(4'd1, 32'hFFFFFFFF, 32'd2, ns, st);
    chk("t2_mult_start", {31'd0, st}, 32'd1);
    chk("t2_mult_nostall", ns, 32'd0);
    rd_q.push_back(32'hFFFFFFFE);
    issue(4'd8, 32'd0, 32'd0, ns, st);
    chk("t2_mflo_stall_cycles", ns, 32'd6);
    rd_q.push_back(32'hFFFFFFFF);
    issue(4'd7, 32'd0, 32'd0, ns, st);
    chk("t2_mfhi_nostall", ns, 32'd0);

    // 3: div 7/2, then mthi held in E while the MDU is busy
    iss_q.push_back('{op: 3'd3, d1: 32'd7, d2: 32'd2});
    issue(4'd3, 32'd7, 32'd2, ns, st);
    chk("t3_div_start", {31'd0, st}, 32'd1);
    iss_q.push_back('{op: 3'd5, d1: 32'h1234, d2: 32'd0});
    issue(4'd5, 32'h1234, 32'd0, ns, st);
    chk("t3_mthi_stall_cycles", ns, 32'd11);
    chk("t3_mthi_no_start", {31'd0, st}, 32'd0);
    rd_q.push_back(32'd3);
    issue(4'd8, 32'd0, 32'd0, ns, st);
    rd_q.push_back(32'h1234);
    issue(4'd7, 32'd0, 32'd0, ns, st);

    // 4: Req suppresses issue; Req mid-WAIT freezes the wait counter
    e_op = 4'd1; e_rs = 32'd3; e_rt = 32'd5; Req = 1'b1;
    @(negedge clk);
    chk("t4_req_start", {31'd0, Start}, 32'd0);
    chk("t4_req_stall", {31'd0, stall}, 32'd0);
    chk("t4_req_mduop", {29'd0, MDUOp}, 32'd0);
    @(posedge clk); #1;
    iss_q.push_back('{op: 3'd1, d1: 32'd3, d2: 32'd5});
    issue(4'd1, 32'd3, 32'd5, ns, st);
    chk("t4_mult_start", {31'd0, st}, 32'd1);
    rd_q.push_back(32'd15);
    issue(4'd8, 32'd0, 32'd0, ns, st);
    chk("t4_mflo_stall_cycles", ns, 32'd6);
    iss_q.push_back('{op: 3'd3, d1: 32'd100, d2: 32'd7});
    issue(4'd3, 32'd100, 32'd7, ns, st);
    repeat (3) begin @(posedge clk); #1; end
    e_op = 4'd5; e_rs = 32'h5555; e_rt = 32'd0; Req = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t4_req_mthi_stall", {31'd0, stall}, 32'd0);
      chk("t4_req_mthi_mduop", {29'd0, MDUOp}, 32'd0);
      @(posedge clk); #1;
    end
    rd_q.push_back(32'd2);
    issue(4'd7, 32'd0, 32'd0, ns, st);
    chk("t4_mfhi_stall_cycles", ns, 32'd8);
    chk("t4_err_clear", {31'd0, err}, 32'd0);
    rd_q.push_back(32'd14);
    issue(4'd8, 32'd0, 32'd0, ns, st);

    // 5: MDU never raises Busy
    mode = 1;
    do_reset();
    iss_q.push_back('{op: 3'd2, d1: 32'd1, d2: 32'd1});
    issue(4'd2, 32'd1, 32'd1, ns, st);
    chk("t5_start", {31'd0, st}, 32'd1);
    @(negedge clk);
    chk("t5_err_in_arm", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("t5_err_set", {31'd0, err}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t5_err_sticky", {31'd0, err}, 32'd1);
    @(posedge clk); #1;
    iss_q.push_back('{op: 3'd6, d1: 32'hAB, d2: 32'd0});
    issue(4'd6, 32'hAB, 32'd0, ns, st);
    chk("t5_back_idle", ns, 32'd0);
    rd_q.push_back(32'hAB);
    issue(4'd8, 32'd0, 32'd0, ns, st);

    // 6: Busy held too long -> timeout error; reset clears it
    mode = 2;
    do_reset();
    @(negedge clk);
    chk("t6_err_cleared_by_reset", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    iss_q.push_back('{op: 3'd3, d1: 32'd9, d2: 32'd3});
    issue(4'd3, 32'd9, 32'd3, ns, st);
    chk("t6_start", {31'd0, st}, 32'd1);
    repeat (13) @(posedge clk);
    @(negedge clk);
    chk("t6_err_before_limit", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("t6_err_at_limit", {31'd0, err}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_err_after_reset", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    rd_q.push_back(32'd0);
    issue(4'd7, 32'd0, 32'd0, ns, st);
    chk("t6_idle_after_reset", ns, 32'd0);
    mode = 0;

    repeat (2) @(posedge clk);
    chk("issue_queue_drained", iss_q.size(), 32'd0);
    chk("read_queue_drained", rd_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
